// File: rtl/pll_sup_pkg.sv
// Shared types and helpers for the PLL lock supervisor and its synchroniser.
package pll_sup_pkg;

  localparam int RETRY_W = 8;

  typedef enum logic [1:0] {
    RESET_PLL = 2'd0,
    WAIT_LOCK = 2'd1,
    STABILISE = 2'd2,
    RUN       = 2'd3
  } pll_sup_state_t;

  // Width of the shared down-counter; the timeout length only counts when use_timeout is set.
  function automatic int cnt_width(input int rst_cycles, input int stable_cycles,
                                   input int timeout_cycles, input bit use_timeout);
    int m;
    m = rst_cycles;
    if (stable_cycles > m) m = stable_cycles;
    if (use_timeout && timeout_cycles > m) m = timeout_cycles;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser into the local clock, synchronous active-high reset.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_supervisor.sv
// Sequences the PLL reset and holds sys_reset until lock is stable.
// PLL_LOCK_SUPERVISOR_TIMEOUT_EN enables the WAIT_LOCK timeout and its retry.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 1000000,
  parameter int STABLE_CYCLES  = 1024
) (
  input  logic               refclk,
  input  logic               rst,
  input  logic               pll_locked,
  output logic               pll_rst,
  output logic               sys_reset,
  output logic               ready,
  output logic               lock_lost,
  output logic [RETRY_W-1:0] retry_count,
  output logic [1:0]         dbg_state
);

`ifdef PLL_LOCK_SUPERVISOR_TIMEOUT_EN
  localparam int CNT_W = cnt_width(PLL_RST_CYCLES, STABLE_CYCLES, LOCK_TIMEOUT, 1'b1);
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(LOCK_TIMEOUT - 1);
`else
  localparam int CNT_W = cnt_width(PLL_RST_CYCLES, STABLE_CYCLES, LOCK_TIMEOUT, 1'b0);
  localparam logic [CNT_W-1:0] WAIT_LOAD = '0;
`endif
  localparam logic [CNT_W-1:0] RST_LOAD    = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LOAD = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  pll_sup_state_t   state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             lk;
  logic             retry_inc;
  logic             lost;

  sync_2ff u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d   (pll_locked),
    .q   (lk)
  );

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    retry_inc = 1'b0;
    lost      = 1'b0;
    case (state)
      RESET_PLL: begin
        if (cnt == '0) begin
          state_n = WAIT_LOCK;
          cnt_n   = WAIT_LOAD;
        end else begin
          cnt_n = cnt - CNT_ONE;
        end
      end
      WAIT_LOCK: begin
        // Lock takes priority over a timeout landing on the same cycle.
        if (lk) begin
          state_n = STABILISE;
          cnt_n   = STABLE_LOAD;
        end
`ifdef PLL_LOCK_SUPERVISOR_TIMEOUT_EN
        else if (cnt == '0) begin
          state_n   = RESET_PLL;
          cnt_n     = RST_LOAD;
          retry_inc = 1'b1;
        end else begin
          cnt_n = cnt - CNT_ONE;
        end
`endif
      end
      STABILISE: begin
        if (!lk) begin
          state_n = WAIT_LOCK;
          cnt_n   = WAIT_LOAD;
        end else if (cnt == '0) begin
          state_n = RUN;
        end else begin
          cnt_n = cnt - CNT_ONE;
        end
      end
      RUN: begin
        if (!lk) begin
          state_n   = RESET_PLL;
          cnt_n     = RST_LOAD;
          retry_inc = 1'b1;
          lost      = 1'b1;
        end
      end
      default: begin
        state_n = RESET_PLL;
        cnt_n   = RST_LOAD;
      end
    endcase
  end

  // Outputs decode the next state so they move on the same edge as the state.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state       <= RESET_PLL;
      cnt         <= RST_LOAD;
      pll_rst     <= 1'b1;
      sys_reset   <= 1'b1;
      ready       <= 1'b0;
      lock_lost   <= 1'b0;
      retry_count <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      pll_rst   <= (state_n == RESET_PLL);
      sys_reset <= (state_n != RUN);
      ready     <= (state_n == RUN);
      lock_lost <= lost;
      if (retry_inc && (retry_count != '1)) begin
        retry_count <= retry_count + RETRY_W'(1);
      end
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor: vector table plus hand-written corner sequences.
module tb_pll_lock_supervisor;
  import pll_sup_pkg::*;

  logic       refclk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
  logic       pll_rst;
  logic       sys_reset;
  logic       ready;
  logic       lock_lost;
  logic [7:0] retry_count;
  logic [1:0] dbg_state;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic r;
    logic l;
    logic exp_pll_rst;
    logic exp_sys_reset;
    logic exp_ready;
    logic exp_lock_lost;
    int   exp_retry;
  } vec_t;

  vec_t tbl[$];

  pll_lock_supervisor #(
    .PLL_RST_CYCLES (4),
    .LOCK_TIMEOUT   (32),
    .STABLE_CYCLES  (8)
  ) dut (
    .refclk      (refclk),
    .rst         (rst),
    .pll_locked  (pll_locked),
    .pll_rst     (pll_rst),
    .sys_reset   (sys_reset),
    .ready       (ready),
    .lock_lost   (lock_lost),
    .retry_count (retry_count),
    .dbg_state   (dbg_state)
  );

  // Clock / reset
  always #10 refclk = ~refclk;

  // Driver: inputs change on the falling edge, outputs sampled 1 time unit after the rising edge.
  task automatic step(input logic r, input logic l);
    @(negedge refclk);
    rst        = r;
    pll_locked = l;
    @(posedge refclk);
    #1;
  endtask

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  task automatic add(input logic r, input logic l, input logic pr, input logic sy,
                     input logic rd, input logic ll, input int rc, input int n);
    vec_t v;
    v.r = r; v.l = l; v.exp_pll_rst = pr; v.exp_sys_reset = sy;
    v.exp_ready = rd; v.exp_lock_lost = ll; v.exp_retry = rc;
    repeat (n) tbl.push_back(v);
  endtask

  initial begin
    int high_cycles;

    // Reset, lock from the start, lock loss in RUN, relock: one row per edge.
    add(1, 1, 1, 1, 0, 0, 0, 1);
    add(0, 1, 1, 1, 0, 0, 0, 3);
    add(0, 1, 0, 1, 0, 0, 0, 9);
    add(0, 1, 0, 0, 1, 0, 0, 2);
    add(0, 0, 0, 0, 1, 0, 0, 2);
    add(0, 0, 1, 1, 0, 1, 1, 1);
    add(0, 0, 1, 1, 0, 0, 1, 3);
    add(0, 0, 0, 1, 0, 0, 1, 1);
    add(0, 1, 0, 1, 0, 0, 1, 10);
    add(0, 1, 0, 0, 1, 0, 1, 2);

    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].l);
      chk($sformatf("row%0d pll_rst", i),   int'(pll_rst),     int'(tbl[i].exp_pll_rst));
      chk($sformatf("row%0d sys_reset", i), int'(sys_reset),   int'(tbl[i].exp_sys_reset));
      chk($sformatf("row%0d ready", i),     int'(ready),       int'(tbl[i].exp_ready));
      chk($sformatf("row%0d lock_lost", i), int'(lock_lost),   int'(tbl[i].exp_lock_lost));
      chk($sformatf("row%0d retry", i),     int'(retry_count), tbl[i].exp_retry);
    end

    // Second lock loss, then rst asserted in the middle of STABILISE.
    step(0, 0);
    step(0, 0);
    step(0, 0);
    chk("second_loss retry", int'(retry_count), 2);
    repeat (7) step(0, 1);
    chk("pre_rst state", int'(dbg_state), int'(STABILISE));
    step(1, 1);
    chk("mid_rst pll_rst", int'(pll_rst), 1);
    chk("mid_rst sys_reset", int'(sys_reset), 1);
    chk("mid_rst ready", int'(ready), 0);
    chk("mid_rst lock_lost", int'(lock_lost), 0);
    chk("mid_rst retry", int'(retry_count), 0);
    chk("mid_rst state", int'(dbg_state), int'(RESET_PLL));

    // One-cycle lock glitch in STABILISE (reset edge above is t=0, glitch at t=8).
    repeat (7) step(0, 1);
    step(0, 0);
    step(0, 1);
    step(0, 1);
    chk("glitch state_wait", int'(dbg_state), int'(WAIT_LOCK));
    step(0, 1);
    chk("glitch state_stab", int'(dbg_state), int'(STABILISE));
    repeat (7) step(0, 1);
    chk("glitch ready_early", int'(ready), 0);
    step(0, 1);
    chk("glitch ready", int'(ready), 1);
    chk("glitch sys_reset", int'(sys_reset), 0);
    chk("glitch retry", int'(retry_count), 0);

    // 300 lock losses from RUN: retry_count saturates at 255.
    for (int i = 0; i < 300; i++) begin
      repeat (3) step(0, 0);
      repeat (14) step(0, 1);
      if (i == 253) chk("sat retry_254", int'(retry_count), 254);
      if (i == 254) chk("sat retry_255", int'(retry_count), 255);
    end
    chk("sat retry_final", int'(retry_count), 255);
    chk("sat ready_final", int'(ready), 1);

`ifdef PLL_LOCK_SUPERVISOR_TIMEOUT_EN
    // No lock: 4-cycle pll_rst pulse, then a timeout every 32 WAIT_LOCK cycles.
    step(1, 0);
    for (int t = 1; t <= 110; t++) begin
      step(0, 0);
      chk($sformatf("to t%0d pll_rst", t), int'(pll_rst), int'((t % 36) < 4));
      chk($sformatf("to t%0d retry", t), int'(retry_count), t / 36);
    end

    // Lock arriving on the timeout cycle wins.
    step(1, 0);
    repeat (33) step(0, 0);
    step(0, 1);
    step(0, 1);
    step(0, 1);
    chk("tie state", int'(dbg_state), int'(STABILISE));
    chk("tie pll_rst", int'(pll_rst), 0);
    chk("tie retry", int'(retry_count), 0);
`else
    // No timeout build: 1000 cycles without lock give a single pll_rst pulse.
    step(1, 0);
    high_cycles = int'(pll_rst);
    for (int t = 1; t <= 1000; t++) begin
      step(0, 0);
      high_cycles += int'(pll_rst);
    end
    chk("notimeout pll_rst_cycles", high_cycles, 4);
    chk("notimeout retry", int'(retry_count), 0);
    chk("notimeout state", int'(dbg_state), int'(WAIT_LOCK));
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
